nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder that processes 4 bits per clock through one 4-bit ripple-carry adder slice.
- The slice is instantiated as ripple_carry_adder_4.
- The block drives the slice's operand and carry inputs from shift registers and captures its sum and carry each cycle.
- Used wherever a wide add is needed without a wide combinational carry chain. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/nibble_serial_adder.sv | 142 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add done 4 bits per clock through one ripple_carry_adder_4 slice.
// Define NIBBLE_SERIAL_ADDER_OVERFLOW_EN to add the o_overflow (signed overflow) output.
module ripple_carry_adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry_in,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_carry_out,
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    output logic             o_overflow,
`endif
    output logic             o_busy
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             rdy_q;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, res_q, res_d, s_q, s_d;
    logic             carry_q, carry_d, co_q, co_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       sum;
    logic             slice_co;
    logic [WIDTH+3:0] res_cat;

    ripple_carry_adder_4 u_slice (
        .a (sh_a_q[3:0]),
        .b (sh_b_q[3:0]),
        .ci(carry_q),
        .s (sum),
        .co(slice_co)
    );

    // New nibble enters at the top while the partial result moves down.
    assign res_cat = {sum, res_q};

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (rdy_q && i_valid) begin
                sh_a_d  = i_a;
                sh_b_d  = i_b;
                carry_d = i_carry_in;
                cnt_d   = '0;
                res_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sh_a_d  = sh_a_q >> 4;
                sh_b_d  = sh_b_q >> 4;
                res_d   = res_cat[WIDTH+3:4];
                carry_d = slice_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    s_d     = res_cat[WIDTH+3:4];
                    co_d    = slice_co;
                    // a^b^s of the top bit recovers the carry into bit WIDTH-1
                    ovf_d   = sh_a_q[3] ^ sh_b_q[3] ^ sum[3] ^ slice_co;
                end
            end
            DONE: if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_ready     = (state_q == IDLE) && rdy_q;
    assign o_valid     = state_q == DONE;
    assign o_busy      = state_q == RUN;
    assign o_s         = s_q;
    assign o_carry_out = co_q;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    assign o_overflow  = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: random and directed adds checked against a cycle-level arithmetic model.
module tb_nibble_serial_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b0, i_carry_in = 1'b0;
    logic [W-1:0] i_a = '0, i_b = '0;
    logic         o_ready, o_valid, o_carry_out, o_busy;
    logic [W-1:0] o_s;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    logic         o_overflow;
`endif

    nibble_serial_adder #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_carry_in(i_carry_in), .o_valid(o_valid),
        .i_ready(i_ready), .o_s(o_s), .o_carry_out(o_carry_out),
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        .o_overflow(o_overflow),
`endif
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int vecs = 0, miss = 0, cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] s;
        s = ref_sum(a, b, cin);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Model: phase 0 idle, 1 computing (m_left cycles to go), 2 result held.
    int         m_phase = 0, m_left = 0;
    logic       m_warm = 1'b0, m_ovf = 1'b0, m_povf = 1'b0;
    logic [W:0] m_res = '0, m_pend = '0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_warm  <= 1'b0;
            m_res   <= '0;
            m_pend  <= '0;
            m_ovf   <= 1'b0;
            m_povf  <= 1'b0;
        end else begin
            m_warm <= 1'b1;
            if (m_phase == 0 && m_warm && i_valid) begin
                m_phase <= 1;
                m_left  <= N;
                m_pend  <= ref_sum(i_a, i_b, i_carry_in);
                m_povf  <= ref_ovf(i_a, i_b, i_carry_in);
            end else if (m_phase == 1) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_phase <= 2;
                    m_res   <= m_pend;
                    m_ovf   <= m_povf;
                end
            end else if (m_phase == 2 && i_ready) begin
                m_phase <= 0;
            end
        end
    end

    always @(negedge i_clk) begin
        chk("ready", o_ready, m_phase == 0 && m_warm);
        chk("busy", o_busy, m_phase == 1);
        chk("valid", o_valid, m_phase == 2);
        chk("sum", o_s, m_res[W-1:0]);
        chk("carry", o_carry_out, m_res[W]);
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        chk("ovf", o_overflow, m_ovf);
`endif
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int hold,
                          output logic [W:0] res, output int lat, output int busy);
        int k = 0;
        i_a = a;
        i_b = b;
        i_carry_in = cin;
        i_valid = 1'b1;
        while (!o_ready && k < 50) begin
            tick;
            k++;
        end
        chk("accept_timeout", k < 50, 1);
        tick;
        i_valid = 1'b0;
        lat = 0;
        busy = 0;
        while (!o_valid && lat < 50) begin
            busy += int'(o_busy);
            tick;
            lat++;
        end
        chk("valid_timeout", o_valid, 1);
        for (int j = 0; j < hold; j++) begin
            i_a = W'($urandom);
            i_b = W'($urandom);
            i_valid = 1'($urandom);
            tick;
            chk("bp_ready", o_ready, 0);
            chk("bp_valid", o_valid, 1);
            chk("bp_result", {o_carry_out, o_s}, ref_sum(a, b, cin));
        end
        res = {o_carry_out, o_s};
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick;
        i_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W:0]   r, r0, r1;
        logic [W-1:0] ra, rb;
        logic         rc;
        int lat, busy, k, t0, t1, got;
        repeat (3) tick;
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_sum", o_s, 0);
        i_rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 0, r, lat, busy);
        chk("basic_result", r, 17'h05555);
        chk("basic_latency", lat, 4);
        chk("basic_busy_cycles", busy, 4);

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, r, lat, busy);
        chk("carry_chain", r, 17'h10000);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, r, lat, busy);
        chk("carry_in_chain", r, 17'h10000);

        run_op(16'h00FF, 16'h0001, 1'b0, 6, r, lat, busy);
        chk("bp_final", r, 17'h00100);
        chk("bp_ready_after", o_ready, 1);

        i_a = 16'h0F0F;
        i_b = 16'h0101;
        i_carry_in = 1'b0;
        i_valid = 1'b1;
        k = 0;
        while (!o_ready && k < 50) begin
            tick;
            k++;
        end
        tick;
        i_valid = 1'b0;
        repeat (2) tick;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_ready", o_ready, 0);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_sum", o_s, 0);
        chk("midrst_carry", o_carry_out, 0);
        repeat (3) begin
            tick;
            chk("midrst_novalid", o_valid, 0);
        end
        i_rst_n = 1'b1;
        run_op(16'h0002, 16'h0003, 1'b0, 0, r, lat, busy);
        chk("after_rst", r, 17'h00005);

        i_ready = 1'b1;
        i_a = 16'h0001;
        i_b = 16'h0001;
        i_carry_in = 1'b0;
        i_valid = 1'b1;
        k = 0;
        while (!o_ready && k < 50) begin
            tick;
            k++;
        end
        tick;
        i_a = 16'hAAAA;
        i_b = 16'h5555;
        i_carry_in = 1'b1;
        got = 0;
        r0 = '0;
        r1 = '0;
        t0 = 0;
        t1 = 0;
        k = 0;
        while (got < 2 && k < 60) begin
            if (o_valid && got == 0) begin r0 = {o_carry_out, o_s}; t0 = cyc; got = 1; end
            else if (o_valid && got == 1) begin r1 = {o_carry_out, o_s}; t1 = cyc; got = 2; end
            if (got < 2) tick;
            k++;
        end
        i_valid = 1'b0;
        tick;
        i_ready = 1'b0;
        chk("b2b_count", got, 2);
        chk("b2b_first", r0, 17'h00002);
        chk("b2b_second", r1, 17'h10000);
        chk("b2b_interval", t1 - t0, N + 2);

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, r, lat, busy);
        chk("ovf_a_res", r, 17'h08000);
        chk("ovf_a", o_overflow, 1);
        run_op(16'h8000, 16'h8000, 1'b0, 1, r, lat, busy);
        chk("ovf_b_res", r, 17'h10000);
        chk("ovf_b", o_overflow, 1);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, r, lat, busy);
        chk("ovf_c_res", r, 17'h10000);
        chk("ovf_c", o_overflow, 0);
`endif

        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), r, lat, busy);
            chk("rand_result", r, ref_sum(ra, rb, rc));
            chk("rand_latency", lat, N);
        end

        repeat (2) tick;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
